// File: rtl/ci_pkg.sv
// -----------------------------------------------------------------------------
// ci_pkg
// Shared types and constants for the custom-instruction accumulate master.
//   ci_state_e        : burst sequencer states
//   CI_DATAB_RESTART  : datab bit that tells the accelerator to restart its sum
//   CI_PIPE_LATENCY   : default accelerator depth in enabled cycles
//   CI_PAD_VALUE      : default flush sample (contributes zero to the sum)
//   ci_datab_word()   : builds the datab word from the restart flag
// -----------------------------------------------------------------------------
package ci_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } ci_state_e;

    localparam int          CI_DATAB_RESTART = 0;
    localparam int          CI_PIPE_LATENCY  = 15;
    localparam logic [31:0] CI_PAD_VALUE     = 32'h0000_0000;

    // Only the restart bit is meaningful; every other datab bit is zero.
    function automatic logic [31:0] ci_datab_word(input logic restart);
        logic [31:0] word;
        word                   = '0;
        word[CI_DATAB_RESTART] = restart;
        return word;
    endfunction

endpackage

// File: rtl/ci_burst_master_if.sv
// -----------------------------------------------------------------------------
// ci_burst_master_if
// Custom-instruction bus between the burst master and the accumulate
// accelerator.
//   ci_start   : instruction start            (master -> accelerator)
//   ci_clk_en  : accelerator pipeline enable  (master -> accelerator)
//   ci_dataa   : sample or pad value          (master -> accelerator)
//   ci_datab   : bit0 restart, rest zero      (master -> accelerator)
//   ci_result  : running accumulated result   (accelerator -> master)
//   ci_done    : accelerator done             (accelerator -> master)
// -----------------------------------------------------------------------------
interface ci_burst_master_if;

    logic        ci_start;
    logic        ci_clk_en;
    logic [31:0] ci_dataa;
    logic [31:0] ci_datab;
    logic [31:0] ci_result;
    logic        ci_done;

    modport master (
        output ci_start,
        output ci_clk_en,
        output ci_dataa,
        output ci_datab,
        input  ci_result,
        input  ci_done
    );

    modport slave (
        input  ci_start,
        input  ci_clk_en,
        input  ci_dataa,
        input  ci_datab,
        output ci_result,
        output ci_done
    );

endinterface

// File: rtl/ci_drain_counter.sv
// -----------------------------------------------------------------------------
// ci_drain_counter
// Loadable down-counter with a zero flag. Saturates at zero so a stray
// decrement can never wrap.
//   clock, reset : clock and synchronous active-high reset (count -> 0)
//   load         : load load_value (has priority over dec)
//   load_value   : value to load
//   dec          : decrement by one when non-zero
//   zero         : count is zero
// -----------------------------------------------------------------------------
module ci_drain_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ci_burst_master.sv
// -----------------------------------------------------------------------------
// ci_burst_master
// Initiator for the pipelined accumulate accelerator. Per command it issues
// cmd_count samples from the source back-to-back (first one flagged as a
// restart), flushes the accelerator with PIPE_LATENCY pad samples and then
// holds the final accumulated value until the consumer accepts it.
//   clock, reset          : clock, synchronous active-high reset
//   cmd_valid/cmd_count   : burst request and sample count
//   cmd_ready             : high while idle
//   src_data/src_valid    : streaming sample source
//   src_ready             : sample consumed this cycle
//   ci_bus (master)       : custom-instruction bus to the accelerator
//   res_data/res_valid    : captured burst result, held until res_ready
//   res_ready             : result consumer accept
//   err_proto             : sticky, accelerator not done on a start cycle
// -----------------------------------------------------------------------------
module ci_burst_master
    import ci_pkg::*;
#(
    parameter int          PIPE_LATENCY = CI_PIPE_LATENCY,
    parameter logic [31:0] PAD_VALUE    = CI_PAD_VALUE,
    parameter int          CNT_W        = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [CNT_W-1:0]         cmd_count,
    output logic                     cmd_ready,
    input  logic [31:0]              src_data,
    input  logic                     src_valid,
    output logic                     src_ready,
    ci_burst_master_if.master        ci_bus,
    output logic [31:0]              res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     err_proto
);

    ci_state_e state;
    logic      first_flag;
    logic      accept;
    logic      issue;
    logic      drain_step;
    logic      samp_zero;
    logic      drain_zero;

    assign accept     = (state == IDLE) && cmd_ready && cmd_valid && (cmd_count != '0);
    assign issue      = (state == ISSUE) && src_valid;
    assign drain_step = (state == DRAIN) && !drain_zero;

    // Combinational so the source sees the consume in the same cycle it offers
    // a sample; masked during reset because that edge discards the sample.
    assign src_ready = issue && !reset;

    // Loaded with count-1 so the zero flag marks the issue of the last sample.
    ci_drain_counter #(.WIDTH(CNT_W)) u_samp_cnt (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (cmd_count - CNT_W'(1)),
        .dec        (issue),
        .zero       (samp_zero)
    );

    // Loaded on the last issue; one pad per non-zero count, capture at zero.
    ci_drain_counter #(.WIDTH(CNT_W)) u_drain_cnt (
        .clock      (clock),
        .reset      (reset),
        .load       (issue && samp_zero),
        .load_value (CNT_W'(PIPE_LATENCY)),
        .dec        (drain_step),
        .zero       (drain_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            first_flag       <= 1'b0;
            cmd_ready        <= 1'b0;
            ci_bus.ci_start  <= 1'b0;
            ci_bus.ci_clk_en <= 1'b0;
            ci_bus.ci_dataa  <= '0;
            ci_bus.ci_datab  <= '0;
            res_data         <= '0;
            res_valid        <= 1'b0;
            err_proto        <= 1'b0;
        end else begin
            if (ci_bus.ci_start && !ci_bus.ci_done) begin
                err_proto <= 1'b1;
            end

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        first_flag <= 1'b1;
                        cmd_ready  <= 1'b0;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    // A stall freezes the accelerator; dataa/datab keep their value.
                    ci_bus.ci_start  <= src_valid;
                    ci_bus.ci_clk_en <= src_valid;
                    if (src_valid) begin
                        ci_bus.ci_dataa <= src_data;
                        ci_bus.ci_datab <= ci_datab_word(first_flag);
                        first_flag      <= 1'b0;
                        if (samp_zero) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (drain_zero) begin
                        // The last pad is still on the bus; ci_result already
                        // includes the final real sample.
                        res_data         <= ci_bus.ci_result;
                        res_valid        <= 1'b1;
                        ci_bus.ci_start  <= 1'b0;
                        ci_bus.ci_clk_en <= 1'b0;
                        state            <= RESULT;
                    end else begin
                        ci_bus.ci_start  <= 1'b1;
                        ci_bus.ci_clk_en <= 1'b1;
                        ci_bus.ci_dataa  <= PAD_VALUE;
                        ci_bus.ci_datab  <= '0;
                    end
                end

                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ci_burst_master.sv
// -----------------------------------------------------------------------------
// tb_ci_burst_master
// Directed bench for ci_burst_master with a stub accumulate accelerator:
// identity inner function, float accumulator, 15 enabled cycles of latency,
// restart on datab[0], advances only when clk_en is high, done = start.
// -----------------------------------------------------------------------------
module tb_ci_burst_master;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_count = '0;
    logic        cmd_ready;
    logic [31:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        src_ready;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        err_proto;

    logic        stub_clear = 1'b1;
    logic        force_done_low = 1'b0;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [31:0] samp_q [4];

    ci_burst_master_if ci_bus ();

    ci_burst_master #(
        .PIPE_LATENCY (15),
        .PAD_VALUE    (32'h0000_0000),
        .CNT_W        (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_count (cmd_count),
        .cmd_ready (cmd_ready),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .ci_bus    (ci_bus),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .err_proto (err_proto)
    );

    always #5 clock = ~clock;

    // ---------------- float helpers for the stub ----------------
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic        s;
        int          e;
        real         m;
        logic [22:0] mant;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        mant = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e), mant};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    // ---------------- stub accelerator ----------------
    // A sample enters stage 0 on its first enabled edge and reaches the
    // accumulator on the 15th.
    localparam int STUB_DEPTH = 14;
    logic [31:0] pipe_d [STUB_DEPTH];
    logic        pipe_r [STUB_DEPTH];
    logic [31:0] acc;

    always @(posedge clock) begin
        if (stub_clear) begin
            acc <= '0;
            for (int i = 0; i < STUB_DEPTH; i++) begin
                pipe_d[i] <= '0;
                pipe_r[i] <= 1'b0;
            end
        end else if (ci_bus.ci_clk_en) begin
            pipe_d[0] <= ci_bus.ci_dataa;
            pipe_r[0] <= ci_bus.ci_datab[0];
            for (int i = 1; i < STUB_DEPTH; i++) begin
                pipe_d[i] <= pipe_d[i-1];
                pipe_r[i] <= pipe_r[i-1];
            end
            acc <= pipe_r[STUB_DEPTH-1] ? pipe_d[STUB_DEPTH-1]
                                        : fadd(acc, pipe_d[STUB_DEPTH-1]);
        end
    end

    assign ci_bus.ci_result = acc;
    assign ci_bus.ci_done   = ci_bus.ci_start & ~force_done_low;

    // ---------------- checking ----------------
    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one burst from samp_q; called on a negative edge. stall_pos is the
    // sample index before which the source goes idle for stall_len cycles;
    // err_at is the cycle (after accept) during which ci_done is forced low.
    task automatic run_burst(input string tag, input int n, input int stall_pos,
                             input int stall_len, input int err_at,
                             input logic [31:0] exp_res, input int exp_lat);
        int cyc, idx, stall_left, restarts, first_at, en_cnt, frozen, lat, consumed;
        cyc = 0; idx = 0; stall_left = stall_len; restarts = 0; first_at = -1;
        en_cnt = 0; frozen = 0; lat = -1; consumed = 0;

        for (int w = 0; w < 50 && !cmd_ready; w++) @(negedge clock);
        check_vec({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_count = 16'(n);
        @(posedge clock);

        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            cmd_valid      = 1'b0;
            force_done_low = (cyc == err_at);
            if (res_valid) begin
                lat = cyc;
                break;
            end
            if (cyc >= 1) begin
                if (ci_bus.ci_clk_en) en_cnt++;
                else                  frozen++;
                if (ci_bus.ci_start && ci_bus.ci_datab[0]) begin
                    restarts++;
                    first_at = cyc;
                end
            end
            if (idx < n) begin
                if (idx == stall_pos && stall_left > 0) begin
                    src_valid = 1'b0;
                    stall_left--;
                end else begin
                    src_valid = 1'b1;
                    src_data  = samp_q[idx];
                    idx++;
                end
            end else begin
                src_valid = 1'b0;
            end
            #1;
            if (src_ready) consumed++;
            @(posedge clock);
            cyc++;
        end
        force_done_low = 1'b0;
        src_valid      = 1'b0;

        check_vec({tag, "_latency"},   32'(lat),      32'(exp_lat));
        check_vec({tag, "_res_data"},  res_data,      exp_res);
        check_vec({tag, "_restarts"},  32'(restarts), 32'd1);
        check_vec({tag, "_first_at"},  32'(first_at), 32'd1);
        check_vec({tag, "_clk_en_on"}, 32'(en_cnt),   32'(n + 15));
        check_vec({tag, "_frozen"},    32'(frozen),   32'(stall_len));
        check_vec({tag, "_consumed"},  32'(consumed), 32'(n));

        res_ready = 1'b1;
        @(negedge clock);
        check_vec({tag, "_res_drop"},  32'(res_valid), 32'd0);
        check_vec({tag, "_idle_rdy"},  32'(cmd_ready), 32'd1);
        res_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int starts, results;

        // Reset state
        repeat (3) @(negedge clock);
        check_vec("rst_cmd_ready", 32'(cmd_ready),        32'd0);
        check_vec("rst_ci_start",  32'(ci_bus.ci_start),  32'd0);
        check_vec("rst_ci_clk_en", 32'(ci_bus.ci_clk_en), 32'd0);
        check_vec("rst_ci_dataa",  ci_bus.ci_dataa,       32'd0);
        check_vec("rst_res_valid", 32'(res_valid),        32'd0);
        check_vec("rst_err_proto", 32'(err_proto),        32'd0);
        check_vec("rst_src_ready", 32'(src_ready),        32'd0);
        reset      = 1'b0;
        stub_clear = 1'b0;
        @(negedge clock);
        check_vec("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // 1.0 + 2.0 + 3.0 = 6.0, no stalls
        samp_q[0] = 32'h3F80_0000; samp_q[1] = 32'h4000_0000; samp_q[2] = 32'h4040_0000;
        run_burst("b3", 3, -1, 0, -1, 32'h40C0_0000, 19);
        check_vec("b3_err", 32'(err_proto), 32'd0);

        // Same burst with a 4-cycle source stall before sample 2
        run_burst("b3_stall", 3, 1, 4, -1, 32'h40C0_0000, 23);

        // Back-to-back: 2.0 + 2.0 = 4.0, then 5.0 alone (res_ready high on entry)
        samp_q[0] = 32'h4000_0000; samp_q[1] = 32'h4000_0000;
        run_burst("b2", 2, -1, 0, -1, 32'h4080_0000, 18);
        samp_q[0] = 32'h40A0_0000;
        res_ready = 1'b1;
        run_burst("b1_pulse", 1, -1, 0, -1, 32'h40A0_0000, 17);

        // Zero-length command is a no-op
        for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clock);
        cmd_valid = 1'b1;
        cmd_count = 16'd0;
        @(negedge clock);
        cmd_valid = 1'b0;
        check_vec("zero_cmd_ready", 32'(cmd_ready), 32'd1);
        starts = 0; results = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ci_bus.ci_start) starts++;
            if (res_valid)       results++;
        end
        check_vec("zero_starts",  32'(starts),  32'd0);
        check_vec("zero_results", 32'(results), 32'd0);

        // Accelerator not done on one issue cycle
        samp_q[0] = 32'h3F80_0000; samp_q[1] = 32'h4000_0000; samp_q[2] = 32'h4040_0000;
        run_burst("b3_err", 3, -1, 0, 1, 32'h40C0_0000, 19);
        repeat (3) @(negedge clock);
        check_vec("err_sticky", 32'(err_proto), 32'd1);

        // Reset during drain cycle 7 of a 7.0 burst
        samp_q[0] = 32'h40E0_0000;
        for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clock);
        cmd_valid = 1'b1;
        cmd_count = 16'd1;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        src_valid = 1'b1;
        src_data  = samp_q[0];
        @(posedge clock);
        @(negedge clock);
        src_valid = 1'b0;
        repeat (6) @(negedge clock);
        check_vec("drain7_clk_en", 32'(ci_bus.ci_clk_en), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_vec("abort_ci_start",  32'(ci_bus.ci_start),  32'd0);
        check_vec("abort_ci_clk_en", 32'(ci_bus.ci_clk_en), 32'd0);
        check_vec("abort_ci_dataa",  ci_bus.ci_dataa,       32'd0);
        check_vec("abort_ci_datab",  ci_bus.ci_datab,       32'd0);
        check_vec("abort_res_valid", 32'(res_valid),        32'd0);
        check_vec("abort_res_data",  res_data,              32'd0);
        check_vec("abort_cmd_ready", 32'(cmd_ready),        32'd0);
        check_vec("abort_err",       32'(err_proto),        32'd0);
        starts = 0; results = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ci_bus.ci_start) starts++;
            if (res_valid)       results++;
        end
        check_vec("abort_no_start",  32'(starts),  32'd0);
        check_vec("abort_no_result", 32'(results), 32'd0);

        samp_q[0] = 32'h4080_0000;
        run_burst("after_abort", 1, -1, 0, -1, 32'h4080_0000, 17);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ci_burst_master.md
Name: ci_burst_master

Overview:
- Initiator side of the team's custom-instruction accumulate interface: `start`/`clk_en`/`dataa`/`datab` out, `result`/`done` back.
- Drives the 15-cycle pipelined accumulate accelerator from a streaming sample source.
- Per command: issues N float samples back-to-back, flagging the first with `datab[0]=1`, then flushes the pipeline with pad samples and captures the final accumulated result.
- Sits between the sample DMA/FIFO and the accelerator; also used as a standalone hardware driver for throughput benchmarking.

Parameters:
PIPE_LATENCY, 15, enabled cycles from issue of a sample until its contribution appears on ci_result
PAD_VALUE, 32'h0000_0000, dataa driven during drain cycles (value whose inner-function contribution is zero)
CNT_W, 16, width of the sample count

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  burst command request
cmd_count  in  CNT_W  number of samples in burst
cmd_ready  out  1  high in IDLE only
src_data  in  32  IEEE-754 single sample
src_valid  in  1  sample available
src_ready  out  1  sample consumed this cycle
ci_start  out  1  custom-instruction start
ci_clk_en  out  1  accelerator pipeline enable
ci_dataa  out  32  sample / pad value
ci_datab  out  32  bit0 = accumulate restart, bits 31:1 = 0
ci_result  in  32  accelerator accumulated result
ci_done  in  1  accelerator done
res_data  out  32  captured burst result
res_valid  out  1  result held valid until accepted
res_ready  in  1  result consumer accept
err_proto  out  1  sticky: ci_done low on an issue cycle

Behaviour:
- Reset values: all outputs 0 except cmd_ready=0 (it rises the cycle after reset deasserts); state IDLE; counters 0; err_proto cleared.
- Reset asserted mid-burst aborts immediately: next edge is IDLE, no result, source not consumed further.
- States: IDLE, ISSUE, DRAIN, RESULT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_count=0: no-op, stay IDLE, no result produced.
  - On cmd_valid with cmd_count>0: latch count, set first flag, go to ISSUE.
- ISSUE:
  - src_ready = src_valid.
  - When src_valid=1: ci_start=1, ci_clk_en=1, ci_dataa=src_data, ci_datab[0]=first flag; first flag clears; remaining count decrements.
  - When src_valid=0 (stall): ci_start=0, ci_clk_en=0 (pipeline frozen, accumulator untouched), ci_dataa holds its last value.
  - After the cycle issuing the last sample: go to DRAIN with drain counter = PIPE_LATENCY.
- One sample per cycle maximum; no bubbles while src_valid stays high.
- DRAIN:
  - Every cycle: ci_start=1, ci_clk_en=1, ci_dataa=PAD_VALUE, ci_datab=0; decrement drain counter.
  - On the cycle the counter reaches 0: capture ci_result into res_data on that edge, go to RESULT.
  - Exactly PIPE_LATENCY drain cycles are issued.
- RESULT:
  - res_valid=1, res_data stable, ci_clk_en=0, ci_start=0.
  - On res_ready: res_valid drops next cycle, go to IDLE.
  - res_ready already high on entry: a single-cycle res_valid pulse.
- err_proto: set if ci_start=1 and ci_done=0 in the same cycle; sticky until reset. Does not alter sequencing.
- Outputs ci_* are registered; ci_dataa/ci_datab change only on issue/drain cycles.
- Latency, N-sample burst with no stalls: cmd accept -> res_valid = 1 + N + PIPE_LATENCY cycles. Each stall cycle adds 1.
- Pad samples left in the pipeline at burst end are discarded by the next burst's restart flag; no extra flush is needed between bursts.

Decomposition:
- Shared package `ci_pkg`:
  - state enum (IDLE/ISSUE/DRAIN/RESULT);
  - CI_DATAB_RESTART bit index (0);
  - default PIPE_LATENCY (15) and PAD_VALUE constants.
- One natural sub-module: `ci_drain_counter`, a loadable down-counter with zero flag, reused for the sample count and the drain count.

Test Plan:
(Bench uses a stub accelerator: inner function = identity, float accumulator, latency 15, restart on datab[0], pipeline advances only on clk_en, done=1 when start.)
- Burst 3 of 1.0, 2.0, 3.0 (0x3F800000, 0x40000000, 0x40400000), no stalls -> restart flag only on first issue; res_data=0x40C00000 (6.0); res_valid exactly 19 cycles after cmd accept.
- Same burst with src_valid low 4 cycles between samples 1 and 2 -> ci_clk_en=0 during the stall; same 0x40C00000; res_valid at cycle 23.
- Two back-to-back bursts (2.0, 2.0) then (5.0) -> results 0x40800000 then 0x40A00000; second burst unaffected by the first burst's pads or sum.
- cmd_count=0 -> no ci_start, no res_valid, cmd_ready back high next cycle.
- Reset asserted during DRAIN cycle 7 -> all outputs 0 next edge, IDLE, no res_valid; a following burst of 4.0 gives 0x40800000.
- Stub forces ci_done=0 on one issue cycle -> err_proto=1 and stays set; result still produced.
